// File: rtl/deferred_check_pkg.sv
// Shared types for the deferred check array: per-channel FSM states and streak width.
package deferred_check_pkg;

  typedef enum logic [1:0] {
    StOk,
    StSuspect,
    StError
  } ch_state_e;

  localparam int unsigned StreakW = 8;

endpackage

// File: rtl/deferred_check_ch.sv
// One check channel: registered match/fail, saturating counters and the OK/SUSPECT/ERROR tracker.
module deferred_check_ch
  import deferred_check_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned FAIL_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             signal_in,
  input  logic             expect_hi,
  input  logic             clr,
  output logic             match,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0]   CntMax = '1;
  localparam logic [StreakW-1:0] Thresh = StreakW'(FAIL_THRESH);
  localparam logic [StreakW-1:0] One    = StreakW'(1);

  logic pass_chk, fail_chk;
  assign pass_chk = en & (signal_in == expect_hi);
  assign fail_chk = en & (signal_in != expect_hi);

  ch_state_e          state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d, streak_inc;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic               match_q, fail_q;

  assign streak_inc = streak_q + One;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOk;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Next state; clr wins over any check on the same edge
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if (clr) begin
      state_d  = StOk;
      streak_d = '0;
    end else begin
      unique case (state_q)
        StOk: begin
          if (fail_chk) begin
            streak_d = One;
            state_d  = (Thresh > One) ? StSuspect : StError;
          end
        end
        StSuspect: begin
          if (fail_chk) begin
            streak_d = streak_inc;
            if (streak_inc >= Thresh) state_d = StError;
          end else if (pass_chk) begin
            streak_d = '0;
            state_d  = StOk;
          end
        end
        StError: begin
          state_d = StError;
        end
        default: begin
          state_d  = StOk;
          streak_d = '0;
        end
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    err = (state_q == StError);
  end

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (clr) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else begin
      if (pass_chk && (pass_cnt_q != CntMax)) pass_cnt_d = pass_cnt_q + 1'b1;
      if (fail_chk && (fail_cnt_q != CntMax)) fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  // Check results are reported even on a clr edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      match_q    <= pass_chk;
      fail_q     <= fail_chk;
    end
  end

  assign match    = match_q;
  assign fail     = fail_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: rtl/deferred_check_array.sv
// Array of independent deferred check channels with a combined error interrupt.
module deferred_check_array
  import deferred_check_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned FAIL_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       signal_in,
  input  logic [N_CH-1:0]       expect_hi,
  input  logic                  clr,
  output logic [N_CH-1:0]       match,
  output logic [N_CH-1:0]       fail,
  output logic [N_CH*CNT_W-1:0] pass_cnt,
  output logic [N_CH*CNT_W-1:0] fail_cnt,
  output logic [N_CH-1:0]       err,
  output logic                  irq
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    deferred_check_ch #(
      .CNT_W      (CNT_W),
      .FAIL_THRESH(FAIL_THRESH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[i]),
      .signal_in(signal_in[i]),
      .expect_hi(expect_hi[i]),
      .clr      (clr),
      .match    (match[i]),
      .fail     (fail[i]),
      .pass_cnt (pass_cnt[i*CNT_W +: CNT_W]),
      .fail_cnt (fail_cnt[i*CNT_W +: CNT_W]),
      .err      (err[i])
    );
  end

  assign irq = |err;

endmodule

// File: tb/tb_deferred_check_array.sv
// Bench for deferred_check_array: directed table, corner sequences and random traffic vs a model.
module tb_deferred_check_array;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TH = 3;
  localparam int CMAX = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   en, signal_in, expect_hi;
  logic           clr;
  logic [N-1:0]   match, fail, err;
  logic [N*W-1:0] pass_cnt, fail_cnt;
  logic           irq;

  deferred_check_array #(
    .N_CH       (N),
    .CNT_W      (W),
    .FAIL_THRESH(TH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .signal_in(signal_in),
    .expect_hi(expect_hi),
    .clr      (clr),
    .match    (match),
    .fail     (fail),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt),
    .err      (err),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: counts and a consecutive-failure tally per channel
  int m_pass[N];
  int m_fail[N];
  int m_streak[N];
  bit m_err[N];
  bit m_match[N];
  bit m_failo[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pass[i] = 0; m_fail[i] = 0; m_streak[i] = 0;
      m_err[i] = 0; m_match[i] = 0; m_failo[i] = 0;
    end
  endtask

  task automatic model_step(input logic [N-1:0] e, input logic [N-1:0] s,
                            input logic [N-1:0] x, input logic c);
    for (int i = 0; i < N; i++) begin
      bit p, f;
      p = e[i] && (s[i] == x[i]);
      f = e[i] && (s[i] != x[i]);
      m_match[i] = p;
      m_failo[i] = f;
      if (c) begin
        m_pass[i] = 0; m_fail[i] = 0; m_streak[i] = 0; m_err[i] = 0;
      end else begin
        if (p && m_pass[i] < CMAX) m_pass[i]++;
        if (f && m_fail[i] < CMAX) m_fail[i]++;
        if (!m_err[i]) begin
          if (f) begin
            m_streak[i]++;
            if (m_streak[i] >= TH) m_err[i] = 1;
          end else if (p) begin
            m_streak[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    bit any_err;
    any_err = 0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s match%0d", tag, i), 32'(match[i]), 32'(m_match[i]));
      chk($sformatf("%s fail%0d", tag, i), 32'(fail[i]), 32'(m_failo[i]));
      chk($sformatf("%s err%0d", tag, i), 32'(err[i]), 32'(m_err[i]));
      chk($sformatf("%s pass_cnt%0d", tag, i), 32'(pass_cnt[i*W +: W]), m_pass[i]);
      chk($sformatf("%s fail_cnt%0d", tag, i), 32'(fail_cnt[i*W +: W]), m_fail[i]);
      any_err |= m_err[i];
    end
    chk($sformatf("%s irq", tag), 32'(irq), 32'(any_err));
  endtask

  task automatic cycle(input logic [N-1:0] e, input logic [N-1:0] s,
                       input logic [N-1:0] x, input logic c, input string tag);
    en = e; signal_in = s; expect_hi = x; clr = c;
    @(posedge clk);
    model_step(e, s, x, c);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] sig;
    logic [N-1:0] exp;
    logic [N-1:0] match;
    logic [N-1:0] fail;
    logic [N-1:0] err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // ch0: always pass; ch1: 3 fails; ch2: fail,fail,pass,fail,fail; ch3 idle
    tbl[0] = '{en: 4'b0111, sig: 4'b0111, exp: 4'b0001, match: 4'b0001, fail: 4'b0110, err: 4'b0000};
    tbl[1] = '{en: 4'b0111, sig: 4'b0111, exp: 4'b0001, match: 4'b0001, fail: 4'b0110, err: 4'b0000};
    tbl[2] = '{en: 4'b0111, sig: 4'b0011, exp: 4'b0001, match: 4'b0101, fail: 4'b0010, err: 4'b0010};
    tbl[3] = '{en: 4'b0101, sig: 4'b0101, exp: 4'b0001, match: 4'b0001, fail: 4'b0100, err: 4'b0010};
    tbl[4] = '{en: 4'b0101, sig: 4'b0101, exp: 4'b0001, match: 4'b0001, fail: 4'b0100, err: 4'b0010};

    en = '0; signal_in = '0; expect_hi = '0; clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int k = 0; k < 5; k++) begin
      en = tbl[k].en; signal_in = tbl[k].sig; expect_hi = tbl[k].exp; clr = 1'b0;
      @(posedge clk);
      model_step(tbl[k].en, tbl[k].sig, tbl[k].exp, 1'b0);
      #1;
      chk($sformatf("tbl%0d match", k), 32'(match), 32'(tbl[k].match));
      chk($sformatf("tbl%0d fail", k), 32'(fail), 32'(tbl[k].fail));
      chk($sformatf("tbl%0d err", k), 32'(err), 32'(tbl[k].err));
      check_model($sformatf("tbl%0d", k));
    end
    chk("dir pass_cnt0", 32'(pass_cnt[0 +: W]), 5);
    chk("dir fail_cnt0", 32'(fail_cnt[0 +: W]), 0);
    chk("dir fail_cnt1", 32'(fail_cnt[W +: W]), 3);
    chk("dir fail_cnt2", 32'(fail_cnt[2*W +: W]), 4);
    chk("dir irq", 32'(irq), 1);

    // Saturation of a 4-bit counter, then clr
    for (int k = 0; k < 20; k++) cycle(4'b0001, 4'b0001, 4'b0001, 1'b0, "sat");
    chk("sat pass_cnt0", 32'(pass_cnt[0 +: W]), 15);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, "clr");
    chk("clr err", 32'(err), 0);
    chk("clr pass_cnt", 32'(pass_cnt), 0);
    chk("clr fail_cnt", 32'(fail_cnt), 0);

    // clr with a simultaneous failing check: reported but not counted
    cycle(4'b0010, 4'b0010, 4'b0000, 1'b1, "clrprio");
    chk("clrprio fail1", 32'(fail[1]), 1);
    chk("clrprio fail_cnt1", 32'(fail_cnt[W +: W]), 0);

    // Reset mid-streak (streak 2) between edges
    cycle(4'b0010, 4'b0010, 4'b0000, 1'b0, "pre_rst");
    cycle(4'b0010, 4'b0010, 4'b0000, 1'b0, "pre_rst");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    #2 rst_n = 1'b1;
    cycle(4'b0010, 4'b0010, 4'b0000, 1'b0, "post_rst1");
    chk("post_rst err1", 32'(err[1]), 0);
    cycle(4'b0010, 4'b0010, 4'b0000, 1'b0, "post_rst2");
    chk("post_rst2 err1", 32'(err[1]), 0);
    cycle(4'b0010, 4'b0010, 4'b0000, 1'b0, "post_rst3");
    chk("post_rst3 err1", 32'(err[1]), 1);

    cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, "clr2");

    // en toggling every cycle on all channels
    for (int k = 0; k < 40; k++) begin
      logic [N-1:0] e;
      e = (k % 2 == 0) ? '1 : '0;
      cycle(e, N'($urandom), N'($urandom), 1'b0, "toggle");
    end

    // Random traffic with occasional clr
    for (int k = 0; k < 400; k++) begin
      cycle(N'($urandom), N'($urandom), N'($urandom), ($urandom_range(0, 15) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
